// File: rtl/sixteen_to_four_serializer.sv
// sixteen_to_four_serializer: accepts a 16-bit multi-hot vector and drains it
// as a stream of 4-bit bit indices, one per code handshake, in priority order.
// LSB_FIRST=1 emits the lowest set bit first, LSB_FIRST=0 the highest.
module sixteen_to_four_serializer #(
   parameter int LSB_FIRST = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic        req_valid,
   output logic        req_ready,
   output logic [3:0]  code,
   output logic        code_valid,
   input  logic        code_ready,
   output logic        code_last,
   output logic        zero_req,
   output logic        busy
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pending_q, pending_d;
   logic        zero_req_q, zero_req_d;

   logic [3:0]  sel_idx;
   logic [15:0] sel_onehot;
   logic        single_bit;
   logic        draining;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [3:0] lowest_idx(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   // Index of the highest set bit; 0 when the vector is empty.
   function automatic logic [3:0] highest_idx(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   // Selection and last-bit detection depend only on the pending register,
   // so the code outputs never combinationally follow code_ready or req.
   always_comb begin
      if (LSB_FIRST != 0) sel_idx = lowest_idx(pending_q);
      else                sel_idx = highest_idx(pending_q);
      sel_onehot = 16'h0001 << sel_idx;
      // Exactly one bit set: non-zero and clearing the lowest bit empties it.
      single_bit = (pending_q != 16'h0000) &&
                   ((pending_q & (pending_q - 16'd1)) == 16'h0000);
   end

   assign draining   = (state_q == ST_DRAIN);
   assign req_ready  = (state_q == ST_IDLE);
   assign code_valid = draining;
   assign busy       = draining;
   assign code       = draining ? sel_idx : 4'h0;
   assign code_last  = draining && single_bit;
   assign zero_req   = zero_req_q;

   // Next-state logic: accept in IDLE, retire one bit per transfer in DRAIN.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      zero_req_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req == 16'h0000) begin
                  // Empty vector: nothing to emit, just flag it for one cycle.
                  zero_req_d = 1'b1;
               end else begin
                  pending_d = req;
                  state_d   = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (code_ready) begin
               pending_d = pending_q & ~sel_onehot;
               if (single_bit) state_d = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            pending_d = 16'h0000;
         end
      endcase
   end

   // State, pending vector and the zero-vector pulse; reset discards any drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pending_q  <= 16'h0000;
         zero_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         zero_req_q <= zero_req_d;
      end
   end

endmodule

// File: tb/tb_sixteen_to_four_serializer.sv
// Bench for sixteen_to_four_serializer: two instances (LSB-first and
// MSB-first) share all inputs and drain in lockstep.
module tb_sixteen_to_four_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] req;
   logic        req_valid;
   logic        code_ready;

   logic        req_ready_l, code_valid_l, code_last_l, zero_req_l, busy_l;
   logic [3:0]  code_l;
   logic        req_ready_m, code_valid_m, code_last_m, zero_req_m, busy_m;
   logic [3:0]  code_m;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sixteen_to_four_serializer #(.LSB_FIRST(1)) dut_l (
      .clk(clk), .rst_n(rst_n), .req(req), .req_valid(req_valid),
      .req_ready(req_ready_l), .code(code_l), .code_valid(code_valid_l),
      .code_ready(code_ready), .code_last(code_last_l),
      .zero_req(zero_req_l), .busy(busy_l)
   );

   sixteen_to_four_serializer #(.LSB_FIRST(0)) dut_m (
      .clk(clk), .rst_n(rst_n), .req(req), .req_valid(req_valid),
      .req_ready(req_ready_m), .code(code_m), .code_valid(code_valid_m),
      .code_ready(code_ready), .code_last(code_last_m),
      .zero_req(zero_req_m), .busy(busy_m)
   );

   typedef struct {
      logic [15:0] req;
      logic [3:0]  first_l;
      logic [3:0]  first_m;
      int          nbits;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready_l"}, 32'(req_ready_l), 32'd1);
      check({tag, "_ready_m"}, 32'(req_ready_m), 32'd1);
      check({tag, "_valid_l"}, 32'(code_valid_l), 32'd0);
      check({tag, "_valid_m"}, 32'(code_valid_m), 32'd0);
      check({tag, "_busy_l"}, 32'(busy_l), 32'd0);
      check({tag, "_busy_m"}, 32'(busy_m), 32'd0);
   endtask

   task automatic check_code(input string tag, input logic [3:0] el, input logic [3:0] em,
                             input logic last);
      check({tag, "_code_l"}, 32'(code_l), 32'(el));
      check({tag, "_code_m"}, 32'(code_m), 32'(em));
      check({tag, "_valid_l"}, 32'(code_valid_l), 32'd1);
      check({tag, "_valid_m"}, 32'(code_valid_m), 32'd1);
      check({tag, "_last_l"}, 32'(code_last_l), 32'(last));
      check({tag, "_last_m"}, 32'(code_last_m), 32'(last));
      check({tag, "_ready_l"}, 32'(req_ready_l), 32'd0);
      check({tag, "_busy_l"}, 32'(busy_l), 32'd1);
   endtask

   // Watchdog: the run must never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         k;
      int         cyc;
      int         n;
      logic [3:0] lastl;
      int         ql[$];
      int         qm[$];
      logic       zf;
      int         el;
      int         em;

      // ---------------- reset with random inputs ----------------
      rst_n      = 1'b0;
      req        = 16'($urandom);
      req_valid  = 1'b1;
      code_ready = 1'($urandom_range(0, 1));
      repeat (3) begin
         @(negedge clk);
         req        = 16'($urandom);
         req_valid  = 1'($urandom_range(0, 1));
         code_ready = 1'($urandom_range(0, 1));
         check_idle("rst");
         check("rst_zero_l", 32'(zero_req_l), 32'd0);
         check("rst_zero_m", 32'(zero_req_m), 32'd0);
         check("rst_code_l", 32'(code_l), 32'd0);
         check("rst_last_l", 32'(code_last_l), 32'd0);
      end
      @(negedge clk);
      rst_n      = 1'b1;
      req_valid  = 1'b0;
      code_ready = 1'b1;
      tick();
      check_idle("post_rst");

      // ---------------- single bit ----------------
      req = 16'h0400; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check_code("single", 4'hA, 4'hA, 1'b1);
      tick();
      check_idle("single_after");

      // ---------------- multi-bit drain ----------------
      req = 16'h8011; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check_code("multi0", 4'h0, 4'hF, 1'b0);
      tick();
      check_code("multi1", 4'h4, 4'h4, 1'b0);
      tick();
      check_code("multi2", 4'hF, 4'h0, 1'b1);
      tick();
      check_idle("multi_after");

      // ---------------- backpressure, ready pattern 1,0,0,... ----------------
      req = 16'hFFFF; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      k   = 0;
      cyc = 0;
      while (k < 16 && cyc < 100) begin
         check_code("bp", 4'(k), 4'(15 - k), (k == 15));
         code_ready = ((cyc % 3) == 0);
         req        = 16'($urandom);
         tick();
         if (code_ready) k++;
         cyc++;
      end
      check("bp_count", 32'(k), 32'd16);
      code_ready = 1'b1;
      check_idle("bp_after");

      // ---------------- zero vector ----------------
      req = 16'h0000; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("zero_pulse_l", 32'(zero_req_l), 32'd1);
      check("zero_pulse_m", 32'(zero_req_m), 32'd1);
      check_idle("zero");
      tick();
      check("zero_gone_l", 32'(zero_req_l), 32'd0);
      check("zero_gone_m", 32'(zero_req_m), 32'd0);
      check_idle("zero_after");

      // ---------------- back-to-back vectors ----------------
      req = 16'h0003; req_valid = 1'b1;
      tick();
      check_code("b2b0", 4'h0, 4'h1, 1'b0);
      req = 16'h0100;
      tick();
      check_code("b2b1", 4'h1, 4'h0, 1'b1);
      tick();
      check_idle("b2b_gap");
      tick();
      check_code("b2b2", 4'h8, 4'h8, 1'b1);
      req = 16'hFFFF;
      tick();
      req_valid = 1'b0;
      check_idle("b2b_end");
      tick();
      check_idle("b2b_quiet");

      // ---------------- table-driven drains ----------------
      tbl[0] = '{16'h0001, 4'h0, 4'h0, 1};
      tbl[1] = '{16'h8000, 4'hF, 4'hF, 1};
      tbl[2] = '{16'h00F0, 4'h4, 4'h7, 4};
      tbl[3] = '{16'hA5A5, 4'h0, 4'hF, 8};
      tbl[4] = '{16'h1248, 4'h3, 4'hC, 4};
      tbl[5] = '{16'hFFFF, 4'h0, 4'hF, 16};
      for (int t = 0; t < 6; t++) begin
         req = tbl[t].req; req_valid = 1'b1; code_ready = 1'b1;
         tick();
         req_valid = 1'b0;
         check("tbl_first_l", 32'(code_l), 32'(tbl[t].first_l));
         check("tbl_first_m", 32'(code_m), 32'(tbl[t].first_m));
         n     = 0;
         lastl = 4'h0;
         while (code_valid_l && n < 20) begin
            n++;
            lastl = code_l;
            check("tbl_last_flag", 32'(code_last_l), 32'(n == tbl[t].nbits));
            tick();
         end
         check("tbl_count", 32'(n), 32'(tbl[t].nbits));
         check("tbl_final_l", 32'(lastl), 32'(tbl[t].first_m));
         check_idle("tbl_after");
      end

      // ---------------- asynchronous reset mid-drain ----------------
      req = 16'hFFFF; req_valid = 1'b1; code_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      check("arst_pre_valid", 32'(code_valid_l), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid_l", 32'(code_valid_l), 32'd0);
      check("arst_valid_m", 32'(code_valid_m), 32'd0);
      check("arst_ready_l", 32'(req_ready_l), 32'd1);
      check("arst_busy_l", 32'(busy_l), 32'd0);
      @(negedge clk);
      rst_n      = 1'b1;
      code_ready = 1'b1;
      tick();
      check_idle("arst_after");

      // ---------------- randomized run against a queue model ----------------
      ql.delete();
      qm.delete();
      zf = 1'b0;
      for (int c = 0; c < 400; c++) begin
         el = (ql.size() != 0) ? ql[0] : 0;
         em = (qm.size() != 0) ? qm[0] : 0;
         check("rnd_valid_l", 32'(code_valid_l), 32'(ql.size() != 0));
         check("rnd_valid_m", 32'(code_valid_m), 32'(qm.size() != 0));
         check("rnd_code_l", 32'(code_l), 32'(el));
         check("rnd_code_m", 32'(code_m), 32'(em));
         check("rnd_last_l", 32'(code_last_l), 32'(ql.size() == 1));
         check("rnd_last_m", 32'(code_last_m), 32'(qm.size() == 1));
         check("rnd_ready_l", 32'(req_ready_l), 32'(ql.size() == 0));
         check("rnd_busy_m", 32'(busy_m), 32'(qm.size() != 0));
         check("rnd_zero_l", 32'(zero_req_l), 32'(zf));
         check("rnd_zero_m", 32'(zero_req_m), 32'(zf));

         req_valid = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0:       req = 16'h0000;
            1:       req = 16'h0001 << $urandom_range(0, 15);
            default: req = 16'($urandom);
         endcase
         code_ready = ($urandom_range(0, 3) != 0);

         zf = 1'b0;
         if (ql.size() == 0) begin
            if (req_valid) begin
               if (req == 16'h0000) begin
                  zf = 1'b1;
               end else begin
                  for (int i = 0; i < 16; i++)  if (req[i]) ql.push_back(i);
                  for (int i = 15; i >= 0; i--) if (req[i]) qm.push_back(i);
               end
            end
         end else if (code_ready) begin
            void'(ql.pop_front());
            void'(qm.pop_front());
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
